// File: rtl/uart_hex_rx_if.sv
// uart_hex_rx_if: bundle of the UART hex receiver's serial input and parsed outputs.
//   rxd        serial input, idle high
//   byte_data  last correctly framed byte
//   byte_vld   1-cycle pulse, byte_data updated
//   frame_err  1-cycle pulse, stop bit was low and the byte was dropped
//   value      last parsed 32-bit word
//   val_vld    1-cycle pulse, value updated
//   digit_cnt  hex digits in the current number, saturating
//   ovf        sticky, too many digits in the current number
//   char_err   1-cycle pulse, unexpected character received
//   busy       frame reception in progress
// The slave modport is the receiver; master is the side feeding rxd and consuming results.
interface uart_hex_rx_if;
  logic        rxd;
  logic [7:0]  byte_data;
  logic        byte_vld;
  logic        frame_err;
  logic [31:0] value;
  logic        val_vld;
  logic [3:0]  digit_cnt;
  logic        ovf;
  logic        char_err;
  logic        busy;

  modport slave (
    input  rxd,
    output byte_data, byte_vld, frame_err, value, val_vld,
    output digit_cnt, ovf, char_err, busy
  );

  modport master (
    output rxd,
    input  byte_data, byte_vld, frame_err, value, val_vld,
    input  digit_cnt, ovf, char_err, busy
  );
endinterface

// File: rtl/uart_hex_rx.sv
// uart_hex_rx: 8N1 UART receiver plus ASCII hex parser. Digits accumulate into a
// 32-bit word that is published on CR; LF is ignored so CR LF line endings work.
// Ports:
//   clk   system clock
//   rstn  synchronous active-low reset
//   bus   uart_hex_rx_if.slave (rxd in; byte/value results and status out)
//
// state | meaning
// IDLE  | line idle, waiting for a low level on synchronised rxd
// START | confirming the start bit at its midpoint
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit; emits byte_vld or frame_err
module uart_hex_rx #(
  parameter int BAUD_DIV   = 10416,
  parameter int MAX_DIGITS = 8
) (
  input logic          clk,
  input logic          rstn,
  uart_hex_rx_if.slave bus
);
  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]    MAXD      = 4'(MAX_DIGITS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          rxd_s1, rxd_s2;
  logic [1:0]    state;
  logic [CW-1:0] bcnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    byte_data;
  logic          byte_vld, frame_err;
  logic [31:0]   accum, value;
  logic          val_vld, ovf, char_err;
  logic [3:0]    digit_cnt;
  logic          is_hex;
  logic [3:0]    nib;

  // Receiver FSM; sync FFs reset high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rxd_s1    <= 1'b1;
      rxd_s2    <= 1'b1;
      state     <= IDLE;
      bcnt      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      byte_data <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rxd_s1    <= bus.rxd;
      rxd_s2    <= rxd_s1;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxd_s2) begin
            state <= START;
            bcnt  <= '0;
          end
        end
        START: begin
          if (bcnt == HALF_LAST) begin
            bcnt    <= '0;
            bit_idx <= '0;
            state   <= rxd_s2 ? IDLE : DATA;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        DATA: begin
          if (bcnt == BIT_LAST) begin
            bcnt  <= '0;
            shift <= {rxd_s2, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: begin
          // Return to IDLE at the stop sample so a short stop bit cannot
          // swallow the next start edge.
          if (bcnt == BIT_LAST) begin
            bcnt  <= '0;
            state <= IDLE;
            if (rxd_s2) begin
              byte_data <= shift;
              byte_vld  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (byte_data >= 8'h30 && byte_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = byte_data[3:0];
    end else if ((byte_data >= 8'h41 && byte_data <= 8'h46) ||
                 (byte_data >= 8'h61 && byte_data <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = byte_data[3:0] + 4'd9;
    end
  end

  // Parser runs one cycle behind byte_vld, so val_vld never shares a cycle with it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      accum     <= '0;
      value     <= '0;
      val_vld   <= 1'b0;
      digit_cnt <= '0;
      ovf       <= 1'b0;
      char_err  <= 1'b0;
    end else begin
      val_vld  <= 1'b0;
      char_err <= 1'b0;
      if (byte_vld) begin
        if (is_hex) begin
          accum <= {accum[27:0], nib};
          if (digit_cnt == MAXD) ovf <= 1'b1;
          else digit_cnt <= digit_cnt + 4'd1;
        end else if (byte_data == 8'h0D) begin
          if (digit_cnt != 4'd0) begin
            value   <= accum;
            val_vld <= 1'b1;
          end
          accum     <= '0;
          digit_cnt <= '0;
          ovf       <= 1'b0;
        end else if (byte_data != 8'h0A) begin
          char_err  <= 1'b1;
          accum     <= '0;
          digit_cnt <= '0;
          ovf       <= 1'b0;
        end
      end
    end
  end

  assign bus.byte_data = byte_data;
  assign bus.byte_vld  = byte_vld;
  assign bus.frame_err = frame_err;
  assign bus.value     = value;
  assign bus.val_vld   = val_vld;
  assign bus.digit_cnt = digit_cnt;
  assign bus.ovf       = ovf;
  assign bus.char_err  = char_err;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_hex_rx.sv
module tb_uart_hex_rx;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  uart_hex_rx_if bus();

  uart_hex_rx #(.BAUD_DIV(BD), .MAX_DIGITS(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Pulse monitor: counts pulses, stamps cycles, flags stretched/coincident pulses.
  int n_byte = 0, n_val = 0, n_ferr = 0, n_cerr = 0, n_dbl = 0, n_coin = 0;
  int val_cyc = 0, cr_cyc = 0;
  logic [31:0] last_val = '0;
  logic pb = 0, pv = 0, pf = 0, pc = 0;
  always @(negedge clk) begin
    if (bus.byte_vld === 1'b1) begin
      n_byte++;
      if (bus.byte_data === 8'h0D) cr_cyc = cyc;
    end
    if (bus.val_vld === 1'b1) begin
      n_val++;
      last_val = bus.value;
      val_cyc = cyc;
    end
    if (bus.frame_err === 1'b1) n_ferr++;
    if (bus.char_err === 1'b1) n_cerr++;
    if ((bus.byte_vld === 1'b1 && pb) || (bus.val_vld === 1'b1 && pv) ||
        (bus.frame_err === 1'b1 && pf) || (bus.char_err === 1'b1 && pc)) n_dbl++;
    if (bus.byte_vld === 1'b1 && bus.val_vld === 1'b1) n_coin++;
    pb = (bus.byte_vld === 1'b1);
    pv = (bus.val_vld === 1'b1);
    pf = (bus.frame_err === 1'b1);
    pc = (bus.char_err === 1'b1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
    bus.rxd = 1'b0;
    cycles(BD);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      cycles(BD);
    end
    bus.rxd = stop_bit;
    cycles(BD);
    bus.rxd = 1'b1;
    cycles(gap);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, gap);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    bus.rxd = 1'b1;
    cycles(3);
    n_checks++; if (bus.value !== 32'h0) begin n_errors++; $display("FAIL reset_value: got %h expected 00000000", bus.value); end
    n_checks++; if (bus.digit_cnt !== 4'd0) begin n_errors++; $display("FAIL reset_digit_cnt: got %0d expected 0", bus.digit_cnt); end
    n_checks++; if ({bus.busy, bus.ovf, bus.byte_vld, bus.val_vld, bus.frame_err, bus.char_err} !== 6'b0) begin
      n_errors++; $display("FAIL reset_flags: got %b expected 000000", {bus.busy, bus.ovf, bus.byte_vld, bus.val_vld, bus.frame_err, bus.char_err}); end
    n_checks++; if (bus.byte_data !== 8'h00) begin n_errors++; $display("FAIL reset_byte_data: got %h expected 00", bus.byte_data); end
    rstn = 1'b1;
    cycles(5);
  endtask

  task automatic test_hex_word;
    int b0, v0;
    b0 = n_byte; v0 = n_val;
    send_str("1A2B3C4D", 2);
    n_checks++; if (bus.digit_cnt !== 4'd8) begin n_errors++; $display("FAIL t1_digit_cnt: got %0d expected 8", bus.digit_cnt); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_errors++; $display("FAIL t1_ovf: got %b expected 0", bus.ovf); end
    send_byte(8'h0D, 1'b1, 2);
    send_byte(8'h0A, 1'b1, 4);
    n_checks++; if (n_byte - b0 != 10) begin n_errors++; $display("FAIL t1_byte_count: got %0d expected 10", n_byte - b0); end
    n_checks++; if (n_val - v0 != 1) begin n_errors++; $display("FAIL t1_val_count: got %0d expected 1", n_val - v0); end
    n_checks++; if (bus.value !== 32'h1A2B3C4D) begin n_errors++; $display("FAIL t1_value: got %h expected 1a2b3c4d", bus.value); end
    n_checks++; if (val_cyc - cr_cyc != 1) begin n_errors++; $display("FAIL t1_val_latency: got %0d expected 1 cycle after CR byte_vld", val_cyc - cr_cyc); end
    n_checks++; if (bus.digit_cnt !== 4'd0) begin n_errors++; $display("FAIL t1_cnt_after_lf: got %0d expected 0", bus.digit_cnt); end
  endtask

  task automatic test_lowercase;
    int v0;
    v0 = n_val;
    send_str("dead\r", 2);
    n_checks++; if (bus.value !== 32'h0000DEAD) begin n_errors++; $display("FAIL t2_dead: got %h expected 0000dead", bus.value); end
    send_str("beef\r", 2);
    n_checks++; if (bus.value !== 32'h0000BEEF) begin n_errors++; $display("FAIL t2_beef: got %h expected 0000beef", bus.value); end
    n_checks++; if (n_val - v0 != 2) begin n_errors++; $display("FAIL t2_val_count: got %0d expected 2", n_val - v0); end
  endtask

  task automatic test_overflow;
    send_str("12345678", 2);
    n_checks++; if (bus.ovf !== 1'b0) begin n_errors++; $display("FAIL t3_ovf_at_8: got %b expected 0", bus.ovf); end
    send_byte("9", 1'b1, 2);
    n_checks++; if (bus.ovf !== 1'b1) begin n_errors++; $display("FAIL t3_ovf_at_9: got %b expected 1", bus.ovf); end
    n_checks++; if (bus.digit_cnt !== 4'd8) begin n_errors++; $display("FAIL t3_digit_cnt: got %0d expected 8", bus.digit_cnt); end
    send_byte(8'h0D, 1'b1, 2);
    n_checks++; if (bus.value !== 32'h23456789) begin n_errors++; $display("FAIL t3_value: got %h expected 23456789", bus.value); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_errors++; $display("FAIL t3_ovf_cleared: got %b expected 0", bus.ovf); end
  endtask

  task automatic test_char_err;
    int c0, v0;
    c0 = n_cerr;
    send_str("12G", 2);
    n_checks++; if (n_cerr - c0 != 1) begin n_errors++; $display("FAIL t4_char_err_count: got %0d expected 1", n_cerr - c0); end
    n_checks++; if (bus.digit_cnt !== 4'd0) begin n_errors++; $display("FAIL t4_cnt_cleared: got %0d expected 0", bus.digit_cnt); end
    send_str("4\r", 2);
    n_checks++; if (bus.value !== 32'h00000004) begin n_errors++; $display("FAIL t4_value: got %h expected 00000004", bus.value); end
    v0 = n_val;
    send_byte(8'h0D, 1'b1, 2);
    n_checks++; if (n_val != v0) begin n_errors++; $display("FAIL t4_lone_cr_pulse: got %0d pulses expected 0", n_val - v0); end
    n_checks++; if (bus.value !== 32'h00000004) begin n_errors++; $display("FAIL t4_lone_cr_value: got %h expected 00000004", bus.value); end
  endtask

  task automatic test_frame_err;
    int b0, f0;
    send_byte("3", 1'b1, 2);
    b0 = n_byte; f0 = n_ferr;
    send_byte(8'h35, 1'b0, 24);
    n_checks++; if (n_ferr - f0 != 1) begin n_errors++; $display("FAIL t5_frame_err_count: got %0d expected 1", n_ferr - f0); end
    n_checks++; if (n_byte != b0) begin n_errors++; $display("FAIL t5_byte_dropped: got %0d byte_vld expected 0", n_byte - b0); end
    n_checks++; if (bus.digit_cnt !== 4'd1) begin n_errors++; $display("FAIL t5_digit_cnt: got %0d expected 1", bus.digit_cnt); end
    // 6-cycle glitch
    b0 = n_byte;
    bus.rxd = 1'b0;
    cycles(3);
    n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL t5_glitch_busy_high: got %b expected 1", bus.busy); end
    cycles(3);
    bus.rxd = 1'b1;
    cycles(6);
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL t5_glitch_busy_low: got %b expected 0", bus.busy); end
    cycles(30);
    n_checks++; if (n_byte != b0 || n_ferr - f0 != 1) begin n_errors++; $display("FAIL t5_glitch_pulses: got %0d byte_vld %0d frame_err expected 0 and 1", n_byte - b0, n_ferr - f0); end
    send_byte(8'h0D, 1'b1, 2);
    n_checks++; if (bus.value !== 32'h00000003) begin n_errors++; $display("FAIL t5_value_after: got %h expected 00000003", bus.value); end
  endtask

  task automatic test_reset_midframe;
    int b0, v0, f0, c0;
    send_byte("5", 1'b1, 2);
    bus.rxd = 1'b0;
    cycles(BD);
    for (int i = 0; i < 4; i++) begin
      bus.rxd = 1'(8'h37 >> i);
      cycles(BD);
    end
    bus.rxd = 1'b1;
    cycles(BD / 2);
    n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL t6_busy_before_reset: got %b expected 1", bus.busy); end
    rstn = 1'b0;
    cycles(1);
    n_checks++; if (bus.value !== 32'h0 || bus.digit_cnt !== 4'd0 || bus.busy !== 1'b0) begin
      n_errors++; $display("FAIL t6_reset_outputs: got value %h cnt %0d busy %b expected 0 0 0", bus.value, bus.digit_cnt, bus.busy); end
    cycles(2);
    rstn = 1'b1;
    b0 = n_byte; v0 = n_val; f0 = n_ferr; c0 = n_cerr;
    cycles(40);
    n_checks++; if (n_byte != b0 || n_val != v0 || n_ferr != f0 || n_cerr != c0) begin
      n_errors++; $display("FAIL t6_no_pulses: got %0d %0d %0d %0d expected 0 0 0 0", n_byte - b0, n_val - v0, n_ferr - f0, n_cerr - c0); end
    send_str("7\r", 2);
    n_checks++; if (bus.value !== 32'h00000007) begin n_errors++; $display("FAIL t6_value: got %h expected 00000007", bus.value); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_val;
    send_str("9F\r", 0);
    cycles(4);
    n_checks++; if (bus.value !== 32'h0000009F) begin n_errors++; $display("FAIL b2b_value: got %h expected 0000009f", bus.value); end
    n_checks++; if (n_val - v0 != 1) begin n_errors++; $display("FAIL b2b_val_count: got %0d expected 1", n_val - v0); end
    n_checks++; if (n_dbl != 0) begin n_errors++; $display("FAIL pulse_width: got %0d stretched pulses expected 0", n_dbl); end
    n_checks++; if (n_coin != 0) begin n_errors++; $display("FAIL pulse_coincide: got %0d byte/val overlaps expected 0", n_coin); end
  endtask

  initial begin
    bus.rxd = 1'b1;
    test_reset();
    test_hex_word();
    test_lowercase();
    test_overflow();
    test_char_err();
    test_frame_err();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
